icache_data_array: RTL and testbench

Parametrised N-way instruction-cache data store. It sits between the icache controller FSM and the external single-port SRAM macros. It serves one fetch-word read per request with a fixed one-cycle SRAM latency. It also assembles AXI refill beats into full-width SRAM bank words and writes them into the victim way, so the controller only supplies index, way and beats.

---
 rtl/icache_data_array_pkg.sv | 24 ++
 rtl/icache_refill_packer.sv | 47 ++++
 rtl/icache_data_array.sv | 181 ++++++++++++++++++
 tb/tb_icache_data_array.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_data_array_pkg.sv
// Shared constants, state encoding and geometry helpers for the icache data array.
// Geometry helpers keep the bank and beat derivations in one place.
package icache_data_array_pkg;

  localparam int XLEN   = 32;
  localparam int BANK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_REFILL,
    ST_WRITE,
    ST_DONE
  } state_e;

  function automatic int calc_banks(input int blk_len);
    return ((2 ** blk_len) * 8) / BANK_W;
  endfunction

  function automatic int calc_nbeat(input int blk_len, input int beat_w);
    return calc_banks(blk_len) * (BANK_W / beat_w);
  endfunction

endpackage

// File: rtl/icache_refill_packer.sv
// Packs refill beats into bank-wide words, counts beats and flags a completed bank word.
// The first beat of each bank word lands in the lowest slot.
module icache_refill_packer
  import icache_data_array_pkg::*;
#(
  parameter int BEAT_W = 64,
  parameter int BANKS  = 4,
  localparam int BPW    = BANK_W / BEAT_W,
  localparam int NBEAT  = BANKS * BPW,
  localparam int CNT_W  = $clog2(NBEAT) + 1,
  localparam int SLOT_W = $clog2(BPW),
  localparam int BIDX_W = CNT_W - SLOT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              beat_fire,
  input  logic [BEAT_W-1:0] beat_data,
  output logic [BANK_W-1:0] asm_word,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [BIDX_W-1:0] wr_bank,
  output logic              word_ready
);

  logic [SLOT_W-1:0] slot;

  assign slot       = beat_cnt[SLOT_W-1:0];
  assign word_ready = beat_fire && (slot == SLOT_W'(BPW - 1));

  // wr_bank captures which bank word the just-completed beats belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_word <= '0;
      beat_cnt <= '0;
      wr_bank  <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (beat_fire) begin
      for (int s = 0; s < BPW; s++) begin
        if (slot == SLOT_W'(s)) asm_word[s*BEAT_W +: BEAT_W] <= beat_data;
      end
      beat_cnt <= beat_cnt + CNT_W'(1);
      if (word_ready) wr_bank <= beat_cnt[CNT_W-1:SLOT_W];
    end
  end

endmodule

// File: rtl/icache_data_array.sv
// N-way icache data store: one-word fetch reads with one-cycle SRAM latency, and
// refill of the victim way from a beat stream, one bank word per SRAM write.
module icache_data_array
  import icache_data_array_pkg::*;
#(
  parameter int WAYS    = 2,
  parameter int IDX_LEN = 7,
  parameter int BLK_LEN = 6,
  parameter int BEAT_W  = 64,
  localparam int BANKS  = calc_banks(BLK_LEN),
  localparam int NB     = WAYS * BANKS,
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_req_i,
  output logic                 rd_ready_o,
  input  logic [IDX_LEN-1:0]   rd_index_i,
  input  logic [BLK_LEN-1:0]   rd_blk_i,
  input  logic [WAY_W-1:0]     rd_way_i,
  output logic                 rd_valid_o,
  output logic [XLEN-1:0]      rd_data_o,
  input  logic                 refill_start_i,
  input  logic [IDX_LEN-1:0]   refill_index_i,
  input  logic [WAY_W-1:0]     refill_way_i,
  input  logic                 beat_valid_i,
  output logic                 beat_ready_o,
  input  logic [BEAT_W-1:0]    beat_data_i,
  input  logic                 beat_last_i,
  output logic                 refill_done_o,
  output logic                 refill_err_o,
  output logic [NB*IDX_LEN-1:0] sram_addr_o,
  output logic [NB-1:0]        sram_cen_o,
  output logic [NB-1:0]        sram_wen_o,
  output logic [NB*BANK_W-1:0] sram_wmask_o,
  output logic [NB*BANK_W-1:0] sram_wdata_o,
  input  logic [NB*BANK_W-1:0] sram_rdata_i,
  output state_e               dbg_state
);

  localparam int BPW    = BANK_W / BEAT_W;
  localparam int NBEAT  = calc_nbeat(BLK_LEN, BEAT_W);
  localparam int CNT_W  = $clog2(NBEAT) + 1;
  localparam int SLOT_W = $clog2(BPW);
  localparam int BIDX_W = CNT_W - SLOT_W;
  localparam int BSEL_W = BLK_LEN - 4;
  localparam int FLAT_W = WAY_W + BSEL_W;

  state_e              state_q, state_d;
  logic [FLAT_W-1:0]   rd_flat_q;
  logic [1:0]          rd_word_q;
  logic [IDX_LEN-1:0]  rf_index_q;
  logic [WAY_W-1:0]    rf_way_q;
  logic                err_q;
  logic                miss_last_q;

  logic [BANK_W-1:0]   asm_word;
  logic [CNT_W-1:0]    beat_cnt;
  logic [BIDX_W-1:0]   wr_bank;
  logic                word_ready;

  logic                start_acc, rd_acc, beat_fire, final_beat, early_last;
  logic [FLAT_W-1:0]   rd_flat, wr_flat;
  logic [BANK_W-1:0]   bank_word;
  logic                unused_blk;

  // Valid/ready: a beat transfers on a cycle where beat_valid_i and beat_ready_o are
  // both high; a read is taken when rd_req_i and rd_ready_o are high and no refill starts.
  assign start_acc  = (state_q == ST_IDLE) && refill_start_i;
  assign rd_acc     = (state_q == ST_IDLE) && !refill_start_i && rd_req_i;
  assign beat_fire  = (state_q == ST_REFILL) && beat_valid_i;
  assign final_beat = (beat_cnt == CNT_W'(NBEAT - 1));
  assign early_last = beat_fire && beat_last_i && !final_beat;

  // Bank count is a power of two, so way*BANKS+bank is a plain concatenation
  assign rd_flat    = {rd_way_i, rd_blk_i[BLK_LEN-1:4]};
  assign wr_flat    = {rf_way_q, wr_bank[BSEL_W-1:0]};
  assign unused_blk = ^rd_blk_i[1:0];

  assign rd_ready_o    = (state_q == ST_IDLE);
  assign beat_ready_o  = (state_q == ST_REFILL);
  assign rd_valid_o    = (state_q == ST_READ);
  assign refill_done_o = (state_q == ST_DONE) && !miss_last_q;
  assign refill_err_o  = err_q || ((state_q == ST_DONE) && miss_last_q);
  assign dbg_state     = state_q;

  icache_refill_packer #(
    .BEAT_W (BEAT_W),
    .BANKS  (BANKS)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_acc),
    .beat_fire  (beat_fire),
    .beat_data  (beat_data_i),
    .asm_word   (asm_word),
    .beat_cnt   (beat_cnt),
    .wr_bank    (wr_bank),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_flat_q   <= '0;
      rd_word_q   <= '0;
      rf_index_q  <= '0;
      rf_way_q    <= '0;
      err_q       <= 1'b0;
      miss_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= early_last;
      if (start_acc) begin
        rf_index_q  <= refill_index_i;
        rf_way_q    <= refill_way_i;
        miss_last_q <= 1'b0;
      end else if (beat_fire && final_beat && !beat_last_i) begin
        miss_last_q <= 1'b1;
      end
      if (rd_acc) begin
        rd_flat_q <= rd_flat;
        rd_word_q <= rd_blk_i[3:2];
      end
    end
  end

  // An early last beat drops the partial bank word even if it just completed
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (refill_start_i)  state_d = ST_REFILL;
        else if (rd_req_i)   state_d = ST_READ;
      end
      ST_READ:   state_d = ST_IDLE;
      ST_REFILL: begin
        if (early_last)      state_d = ST_IDLE;
        else if (word_ready) state_d = ST_WRITE;
      end
      ST_WRITE:  state_d = (wr_bank == BIDX_W'(BANKS - 1)) ? ST_DONE : ST_REFILL;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sram_addr_o  = '0;
    sram_cen_o   = '1;
    sram_wen_o   = '1;
    sram_wmask_o = '1;
    sram_wdata_o = '0;
    for (int b = 0; b < NB; b++) begin
      if (rd_acc && (rd_flat == FLAT_W'(b))) begin
        sram_cen_o[b]                      = 1'b0;
        sram_addr_o[b*IDX_LEN +: IDX_LEN] = rd_index_i;
      end
      if ((state_q == ST_WRITE) && (wr_flat == FLAT_W'(b))) begin
        sram_cen_o[b]                      = 1'b0;
        sram_wen_o[b]                      = 1'b0;
        sram_wmask_o[b*BANK_W +: BANK_W]   = '0;
        sram_addr_o[b*IDX_LEN +: IDX_LEN] = rf_index_q;
        sram_wdata_o[b*BANK_W +: BANK_W]   = asm_word;
      end
    end
  end

  always_comb begin
    bank_word = '0;
    rd_data_o = '0;
    for (int b = 0; b < NB; b++) begin
      if (rd_flat_q == FLAT_W'(b)) bank_word = sram_rdata_i[b*BANK_W +: BANK_W];
    end
    if (state_q == ST_READ) begin
      for (int w = 0; w < 4; w++) begin
        if (rd_word_q == 2'(w)) rd_data_o = bank_word[w*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: tb/tb_icache_data_array.sv
// Directed bench for icache_data_array: default geometry with an SRAM model, plus a
// 4-way / 32-bit-beat instance checked on its refill write stream.
module tb_icache_data_array;
  import icache_data_array_pkg::*;

  localparam int W = 139;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance
  logic        rd_req = 1'b0, rd_ready, rd_valid;
  logic [6:0]  rd_index = '0;
  logic [5:0]  rd_blk = '0;
  logic [0:0]  rd_way = '0;
  logic [31:0] rd_data;
  logic        refill_start = 1'b0;
  logic [6:0]  refill_index = '0;
  logic [0:0]  refill_way = '0;
  logic        beat_valid = 1'b0, beat_ready, beat_last = 1'b0;
  logic [63:0] beat_data = '0;
  logic        refill_done, refill_err;
  logic [8*7-1:0]   sram_addr;
  logic [7:0]       sram_cen, sram_wen;
  logic [8*128-1:0] sram_wmask, sram_wdata, sram_rdata;
  state_e      dbg_state;

  // 4-way, 32-bit beat instance
  logic        rd_ready_4, rd_valid_4;
  logic [31:0] rd_data_4;
  logic        refill_start_4 = 1'b0;
  logic [6:0]  refill_index_4 = '0;
  logic [1:0]  refill_way_4 = '0;
  logic        beat_valid_4 = 1'b0, beat_ready_4, beat_last_4 = 1'b0;
  logic [31:0] beat_data_4 = '0;
  logic        refill_done_4, refill_err_4;
  logic [16*7-1:0]   sram_addr_4;
  logic [15:0]       sram_cen_4, sram_wen_4;
  logic [16*128-1:0] sram_wmask_4, sram_wdata_4;
  logic [16*128-1:0] sram_rdata_4 = '0;
  state_e      dbg_state_4;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] obs4_q[$];

  logic [127:0] mem_a [8][128];
  logic [63:0]  beats_a [8];
  logic [63:0]  b1111 [8];
  logic [63:0]  bc [8];
  logic [31:0]  beats_4 [16];

  typedef struct {
    logic [0:0]  way;
    logic [6:0]  idx;
    logic [5:0]  blk;
    logic [7:0]  cen;
    logic [31:0] data;
  } rd_vec_t;
  rd_vec_t rv[7];

  icache_data_array u_dut (
    .clk(clk), .rst(rst),
    .rd_req_i(rd_req), .rd_ready_o(rd_ready), .rd_index_i(rd_index), .rd_blk_i(rd_blk),
    .rd_way_i(rd_way), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .refill_start_i(refill_start), .refill_index_i(refill_index), .refill_way_i(refill_way),
    .beat_valid_i(beat_valid), .beat_ready_o(beat_ready), .beat_data_i(beat_data),
    .beat_last_i(beat_last), .refill_done_o(refill_done), .refill_err_o(refill_err),
    .sram_addr_o(sram_addr), .sram_cen_o(sram_cen), .sram_wen_o(sram_wen),
    .sram_wmask_o(sram_wmask), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
    .dbg_state(dbg_state)
  );

  icache_data_array #(.WAYS(4), .IDX_LEN(7), .BLK_LEN(6), .BEAT_W(32)) u_dut4 (
    .clk(clk), .rst(rst),
    .rd_req_i(1'b0), .rd_ready_o(rd_ready_4), .rd_index_i(7'h0), .rd_blk_i(6'h0),
    .rd_way_i(2'h0), .rd_valid_o(rd_valid_4), .rd_data_o(rd_data_4),
    .refill_start_i(refill_start_4), .refill_index_i(refill_index_4), .refill_way_i(refill_way_4),
    .beat_valid_i(beat_valid_4), .beat_ready_o(beat_ready_4), .beat_data_i(beat_data_4),
    .beat_last_i(beat_last_4), .refill_done_o(refill_done_4), .refill_err_o(refill_err_4),
    .sram_addr_o(sram_addr_4), .sram_cen_o(sram_cen_4), .sram_wen_o(sram_wen_4),
    .sram_wmask_o(sram_wmask_4), .sram_wdata_o(sram_wdata_4), .sram_rdata_i(sram_rdata_4),
    .dbg_state(dbg_state_4)
  );

  // SRAM model with masked write and registered read; every write is logged
  always @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (!sram_cen[b]) begin
        if (!sram_wen[b]) begin
          mem_a[b][sram_addr[b*7 +: 7]] <= (mem_a[b][sram_addr[b*7 +: 7]] & sram_wmask[b*128 +: 128])
                                          | (sram_wdata[b*128 +: 128] & ~sram_wmask[b*128 +: 128]);
          obs_q.push_back({4'(b), sram_addr[b*7 +: 7], sram_wdata[b*128 +: 128]});
        end
        sram_rdata[b*128 +: 128] <= mem_a[b][sram_addr[b*7 +: 7]];
      end
    end
    for (int b = 0; b < 16; b++) begin
      if (!sram_cen_4[b] && !sram_wen_4[b])
        obs4_q.push_back({4'(b), sram_addr_4[b*7 +: 7], sram_wdata_4[b*128 +: 128]});
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic compare_writes(input string name, inout logic [W-1:0] oq[$]);
    int n;
    check({name, "_count"}, oq.size(), exp_q.size());
    n = (oq.size() < exp_q.size()) ? oq.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_wr%0d", name, i), oq[i], exp_q[i]);
    oq.delete();
    exp_q.delete();
  endtask

  task automatic refill_a(input int way, input int idx, input int n, input int last_idx,
                          output int done_n, output int err_n, output int done_at, output int err_at);
    int k, guard, cyc;
    logic acc;
    @(posedge clk); #1;
    refill_start = 1'b1; refill_index = idx[6:0]; refill_way = way[0:0];
    @(posedge clk); #1;
    refill_start = 1'b0;
    k = 0; guard = 0; cyc = 0; done_n = 0; err_n = 0; done_at = 0; err_at = 0;
    while (k < n && guard < 200) begin
      beat_valid = 1'b1; beat_data = beats_a[k]; beat_last = (k == last_idx);
      @(negedge clk); cyc++;
      acc = beat_ready;
      if (refill_done) begin done_n++; done_at = cyc; end
      if (refill_err)  begin err_n++;  err_at = cyc;  end
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    beat_valid = 1'b0; beat_last = 1'b0;
    check("beats_accepted", k, n);
    repeat (8) begin
      @(negedge clk); cyc++;
      if (refill_done) begin done_n++; done_at = cyc; end
      if (refill_err)  begin err_n++;  err_at = cyc;  end
    end
  endtask

  task automatic push_exp_a(input int way, input int idx, input int nwr);
    for (int j = 0; j < nwr; j++)
      exp_q.push_back({4'(way*4 + j), 7'(idx), beats_a[2*j+1], beats_a[2*j]});
  endtask

  task automatic do_read(input rd_vec_t v, input int n);
    @(posedge clk); #1;
    rd_req = 1'b1; rd_way = v.way; rd_index = v.idx; rd_blk = v.blk;
    @(negedge clk);
    check($sformatf("rd_cen_%0d", n), sram_cen, v.cen);
    check($sformatf("rd_wen_%0d", n), sram_wen, 8'hFF);
    check($sformatf("rd_ready_idle_%0d", n), rd_ready, 1'b1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    check($sformatf("rd_valid_%0d", n), rd_valid, 1'b1);
    check($sformatf("rd_data_%0d", n), rd_data, v.data);
    check($sformatf("rd_ready_busy_%0d", n), rd_ready, 1'b0);
    check($sformatf("rd_cen_idle_%0d", n), sram_cen, 8'hFF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, en, dat, eat, k, guard, cyc;
    logic acc;

    for (int i = 0; i < 8; i++) begin
      b1111[i] = 64'h1111_1111_1111_1110 | 64'(i);
      bc[i]    = {32'(32'hC1 + 2*i), 32'(32'hC0 + 2*i)};
    end
    for (int i = 0; i < 16; i++) beats_4[i] = 32'hF000_0000 | 32'(i);

    rv[0] = '{1'b1, 7'h15, 6'h24, 8'hBF, 32'h1111_1111};
    rv[1] = '{1'b1, 7'h15, 6'h00, 8'hEF, 32'h1111_1110};
    rv[2] = '{1'b1, 7'h15, 6'h38, 8'h7F, 32'h1111_1117};
    rv[3] = '{1'b0, 7'h15, 6'h04, 8'hFE, 32'h0000_00C1};
    rv[4] = '{1'b0, 7'h15, 6'h2C, 8'hFB, 32'h0000_00CB};
    rv[5] = '{1'b0, 7'h15, 6'h1C, 8'hFD, 32'h0000_00C7};
    rv[6] = '{1'b0, 7'h15, 6'h30, 8'hF7, 32'h0000_00CC};

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_flags", {rd_valid, refill_done, refill_err, beat_ready, rd_ready}, 5'b00001);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_cen", sram_cen, 8'hFF);
    check("rst_wen", sram_wen, 8'hFF);
    check("rst_wmask", &sram_wmask, 1'b1);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // full refill of way 1, set 0x15
    for (int i = 0; i < 8; i++) beats_a[i] = b1111[i];
    refill_a(1, 'h15, 8, 7, dn, en, dat, eat);
    check("rf1_done_pulses", dn, 1);
    check("rf1_err_pulses", en, 0);
    check("rf1_done_cycle", dat, 13);
    push_exp_a(1, 'h15, 4);
    compare_writes("rf1", obs_q);

    // full refill of way 0, set 0x15
    for (int i = 0; i < 8; i++) beats_a[i] = bc[i];
    refill_a(0, 'h15, 8, 7, dn, en, dat, eat);
    check("rf0_done_pulses", dn, 1);
    check("rf0_err_pulses", en, 0);
    push_exp_a(0, 'h15, 4);
    compare_writes("rf0", obs_q);

    // back-to-back reads from the vector table
    for (int i = 0; i < 7; i++) do_read(rv[i], i);

    // refill and read in the same cycle: refill wins
    @(posedge clk); #1;
    refill_start = 1'b1; refill_index = 7'h50; refill_way = 1'b0;
    rd_req = 1'b1; rd_way = 1'b1; rd_index = 7'h15; rd_blk = 6'h00;
    @(negedge clk);
    check("coll_cen", sram_cen, 8'hFF);
    @(posedge clk); #1;
    refill_start = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    check("coll_rd_valid", rd_valid, 1'b0);
    check("coll_beat_ready", beat_ready, 1'b1);
    @(posedge clk); #1;
    beat_valid = 1'b1; beat_last = 1'b1; beat_data = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk); #1;
    beat_valid = 1'b0; beat_last = 1'b0;
    @(negedge clk);
    check("coll_err", {refill_err, refill_done}, 2'b10);
    check("coll_state", dbg_state, ST_IDLE);
    @(negedge clk);
    check("coll_err_pulse", refill_err, 1'b0);
    check("coll_no_write", obs_q.size(), 0);

    // last on beat 3: only bank 0 of the way is written
    for (int i = 0; i < 8; i++) beats_a[i] = b1111[i];
    refill_a(1, 'h22, 4, 3, dn, en, dat, eat);
    check("early_err_pulses", en, 1);
    check("early_done_pulses", dn, 0);
    check("early_err_cycle", eat, 6);
    push_exp_a(1, 'h22, 1);
    compare_writes("early", obs_q);

    // eight beats without last: full line written, error instead of done
    refill_a(0, 'h23, 8, -1, dn, en, dat, eat);
    check("nolast_err_pulses", en, 1);
    check("nolast_done_pulses", dn, 0);
    check("nolast_err_cycle", eat, 13);
    push_exp_a(0, 'h23, 4);
    compare_writes("nolast", obs_q);

    // reset in the middle of a refill after three beats
    @(posedge clk); #1;
    refill_start = 1'b1; refill_index = 7'h40; refill_way = 1'b0;
    @(posedge clk); #1;
    refill_start = 1'b0;
    k = 0; guard = 0;
    while (k < 3 && guard < 50) begin
      beat_valid = 1'b1; beat_data = b1111[k];
      @(negedge clk);
      acc = beat_ready;
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    check("mid_beats", k, 3);
    check("mid_pre_writes", obs_q.size(), 1);
    obs_q.delete();
    rst = 1'b1;
    #1;
    check("mid_rst_flags", {rd_valid, refill_done, refill_err, beat_ready, rd_ready}, 5'b00001);
    check("mid_rst_cen", sram_cen, 8'hFF);
    check("mid_rst_wen", sram_wen, 8'hFF);
    check("mid_rst_wmask", &sram_wmask, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    beat_valid = 1'b0;
    check("mid_no_write", obs_q.size(), 0);
    check("mid_state", dbg_state, ST_IDLE);
    do_read(rv[0], 100);

    // 4-way, 32-bit beats: way 2, set 0x33 -> banks 8..11
    @(posedge clk); #1;
    refill_start_4 = 1'b1; refill_index_4 = 7'h33; refill_way_4 = 2'd2;
    @(posedge clk); #1;
    refill_start_4 = 1'b0;
    k = 0; guard = 0; cyc = 0; dn = 0; dat = 0; en = 0;
    while (k < 16 && guard < 200) begin
      beat_valid_4 = 1'b1; beat_data_4 = beats_4[k]; beat_last_4 = (k == 15);
      @(negedge clk); cyc++;
      acc = beat_ready_4;
      if (refill_done_4) begin dn++; dat = cyc; end
      if (refill_err_4) en++;
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    beat_valid_4 = 1'b0; beat_last_4 = 1'b0;
    check("w4_beats", k, 16);
    repeat (8) begin
      @(negedge clk); cyc++;
      if (refill_done_4) begin dn++; dat = cyc; end
      if (refill_err_4) en++;
    end
    check("w4_done_pulses", dn, 1);
    check("w4_err_pulses", en, 0);
    check("w4_done_cycle", dat, 21);
    exp_q.push_back({4'd8,  7'h33, 128'hF0000003_F0000002_F0000001_F0000000});
    exp_q.push_back({4'd9,  7'h33, 128'hF0000007_F0000006_F0000005_F0000004});
    exp_q.push_back({4'd10, 7'h33, 128'hF000000B_F000000A_F0000009_F0000008});
    exp_q.push_back({4'd11, 7'h33, 128'hF000000F_F000000E_F000000D_F000000C});
    compare_writes("w4", obs4_q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
